inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch stage for the MIPS32 pipeline. Keeps the program counter and
//  drives the read port of inst_mem (addr_r / data_out, 1-cycle synchronous read).
//  Buffers returned words in a 2-entry skid queue and presents them with their PC
//  to decode over a valid/ready handshake. Supports single-cycle redirect
//  (branch/jump) with flush.
// PARAMETERS
//  AW        10  word-address width; matches inst_mem addr_r
//  DW        32  instruction width
//  RESET_PC  0   word address fetched first after reset
// PORTS
//  clk            in   1   rising-edge clock
//  clr_n          in   1   asynchronous, active-low reset
//  imem_addr      out  AW  to inst_mem addr_r; memory samples it every posedge
//  imem_data      in   DW  from inst_mem data_out = mem[addr sampled at previous edge]
//  redirect_valid in   1   load new PC this cycle; flush everything older
//  redirect_pc    in   AW  target word address
//  if_valid       out  1   if_instr/if_pc hold a valid fetched instruction
//  if_instr       out  DW  instruction word (queue head)
//  if_pc          out  AW  word address of if_instr
//  id_ready       in   1   decode accepts head when if_valid & id_ready (pop)
// BEHAVIOUR
//  - State: req_pc (imem_addr = req_pc), inflight bit + inflight_pc, 2-entry queue {pc,instr}.
//  - Reset (async, clr_n=0): req_pc=RESET_PC, inflight=0, queue empty; if_valid=0,
//    if_instr=0, if_pc=0 immediately, no clock needed. Outputs are 0 whenever if_valid=0.
//  - Word addressing: PC increments by 1, wraps 2^AW-1 -> 0 without error.
//  - Issue at an edge when (count + inflight - pop) < 2: inflight<=1, inflight_pc<=req_pc,
//    req_pc<=req_pc+1. Otherwise inflight<=0, req_pc held (memory re-reads, ignored).
//  - Push: when inflight=1 at an edge, {inflight_pc, imem_data} enters queue tail.
//    Credit rule guarantees the queue never overflows; push and pop may coincide.
//  - Throughput: 1 instr/cycle with id_ready held high. Reset release -> first
//    if_valid after 2nd posedge (edge 1 issue RESET_PC, edge 2 push).
//  - Stall (id_ready=0): head and outputs hold stable; queue fills to 2, issue stops;
//    no instruction dropped or duplicated on release. Release: pop and issue same edge.
//  - Redirect (redirect_valid=1 at edge n): priority over everything; queue cleared,
//    inflight<=0, req_pc<=redirect_pc, no issue. Edge n+1 issues redirect_pc, edge n+2
//    pushes it: if_valid with if_pc=redirect_pc in cycle after edge n+2.
//  - Redirect with pop same cycle: head is counted as accepted by decode; remaining
//    entries flushed. Back-to-back redirects: last one wins.
//  - imem_data never sampled unless inflight=1; X on imem_data otherwise is harmless.
// TESTING
//  1. mem[0..3]={A0,A1,A2,A3}, release clr_n, id_ready=1 -> if_valid rises after 2nd
//     posedge; if_pc 0,1,2,3 with A0..A3 on consecutive cycles.
//  2. Stream, id_ready=0 for 5 cycles while if_pc=2 -> if_pc=2/if_instr=A2 held,
//     imem_addr frozen at 4; after release sequence 2,3,4 with no gaps/duplicates.
//  3. Stream, redirect_valid=1 redirect_pc=0x100 at edge n -> if_valid=0 after edge n,
//     if_pc=0x100 valid after edge n+2, then 0x101.
//  4. Redirect to 0x3FE, id_ready=1 -> if_pc 0x3FE, 0x3FF, 0x000 with correct words.
//  5. Queue full (stalled), clr_n pulsed low mid-cycle -> if_valid=0 and
//     imem_addr=RESET_PC without a clock edge; restart behaves as test 1.
//  6. redirect_valid and if_valid&id_ready same cycle -> head consumed once,
//     queued second entry never appears, next if_pc=redirect_pc.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory,
// and holds returned words in a 2-entry skid queue for decode.
module inst_fetch #(
    parameter int              AW       = 10,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          clr_n,
    output logic [AW-1:0] imem_addr,
    input  logic [DW-1:0] imem_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          if_valid,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    input  logic          id_ready
);

    logic [AW-1:0] r_req_pc;
    logic          r_inflight;
    logic [AW-1:0] r_infl_pc;
    logic [1:0]    r_count;
    logic [AW-1:0] r_q0_pc;
    logic [DW-1:0] r_q0_instr;
    logic [AW-1:0] r_q1_pc;
    logic [DW-1:0] r_q1_instr;

    logic          w_pop;
    logic [2:0]    w_occ;
    logic          w_issue;
    logic          w_wr_hi;
    logic [AW-1:0] w_n_req_pc;
    logic          w_n_inflight;
    logic [AW-1:0] w_n_infl_pc;
    logic [1:0]    w_n_count;
    logic [AW-1:0] w_n_q0_pc;
    logic [DW-1:0] w_n_q0_instr;
    logic [AW-1:0] w_n_q1_pc;
    logic [DW-1:0] w_n_q1_instr;

    assign w_pop   = (r_count != 2'd0) && id_ready;
    // Credit: entries held plus the word in flight, minus the one leaving this edge.
    assign w_occ   = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_issue = (w_occ < 3'd2);
    assign w_wr_hi = ((r_count - {1'b0, w_pop}) != 2'd0);

    always_comb begin
        w_n_req_pc   = r_req_pc;
        w_n_inflight = 1'b0;
        w_n_infl_pc  = r_infl_pc;
        w_n_count    = r_count;
        w_n_q0_pc    = r_q0_pc;
        w_n_q0_instr = r_q0_instr;
        w_n_q1_pc    = r_q1_pc;
        w_n_q1_instr = r_q1_instr;
        if (redirect_valid) begin
            w_n_count  = 2'd0;
            w_n_req_pc = redirect_pc;
        end else begin
            if (w_pop) begin
                w_n_q0_pc    = r_q1_pc;
                w_n_q0_instr = r_q1_instr;
            end
            if (r_inflight) begin
                if (w_wr_hi) begin
                    w_n_q1_pc    = r_infl_pc;
                    w_n_q1_instr = imem_data;
                end else begin
                    w_n_q0_pc    = r_infl_pc;
                    w_n_q0_instr = imem_data;
                end
            end
            w_n_count = r_count - {1'b0, w_pop} + {1'b0, r_inflight};
            if (w_issue) begin
                w_n_inflight = 1'b1;
                w_n_infl_pc  = r_req_pc;
                w_n_req_pc   = r_req_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_infl_pc  <= '0;
            r_count    <= 2'd0;
            r_q0_pc    <= '0;
            r_q0_instr <= '0;
            r_q1_pc    <= '0;
            r_q1_instr <= '0;
        end else begin
            r_req_pc   <= w_n_req_pc;
            r_inflight <= w_n_inflight;
            r_infl_pc  <= w_n_infl_pc;
            r_count    <= w_n_count;
            r_q0_pc    <= w_n_q0_pc;
            r_q0_instr <= w_n_q0_instr;
            r_q1_pc    <= w_n_q1_pc;
            r_q1_instr <= w_n_q1_instr;
        end
    end

    assign imem_addr = r_req_pc;
    assign if_valid  = (r_count != 2'd0);
    assign if_pc     = if_valid ? r_q0_pc : '0;
    assign if_instr  = if_valid ? r_q0_instr : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run against a
// stream-level model (expected next PC and fill latency since last flush).
module tb_inst_fetch;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          if_valid;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          id_ready = 1'b0;

    logic [DW-1:0] mem [0:1023];
    int n_checks = 0;
    int n_fail = 0;

    inst_fetch #(.AW(AW), .DW(DW), .RESET_PC('0)) dut (
        .clk(clk), .clr_n(clr_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves clr_n released just after an edge; the next edge is the first issue.
    task automatic do_reset;
        clr_n = 1'b0;
        id_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        #3;
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if_valid); end
        n_checks++; if (if_pc !== '0) begin n_fail++; $display("FAIL reset_pc got %h want 0", if_pc); end
        n_checks++; if (if_instr !== '0) begin n_fail++; $display("FAIL reset_instr got %h want 0", if_instr); end
        n_checks++; if (imem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        repeat (3) tick();
        n_checks++; if (if_valid !== 1'b0 || imem_addr !== '0) begin
            n_fail++; $display("FAIL reset_hold got valid=%b addr=%h want 0/0", if_valid, imem_addr);
        end
    endtask

    task automatic test_stream;
        do_reset();
        tick();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_edge1_valid got %b want 0", if_valid); end
        n_checks++; if (imem_addr !== 10'd1) begin n_fail++; $display("FAIL stream_edge1_addr got %h want 1", imem_addr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== AW'(i) || if_instr !== mem[i]) begin
                n_fail++;
                $display("FAIL stream_word%0d got v=%b pc=%h instr=%h want 1/%h/%h", i, if_valid, if_pc, if_instr, i, mem[i]);
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        repeat (4) tick();
        n_checks++; if (if_pc !== 10'd2) begin n_fail++; $display("FAIL stall_pre_pc got %h want 2", if_pc); end
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 10'd2 || if_instr !== mem[2] || imem_addr !== 10'd4) begin
                n_fail++;
                $display("FAIL stall_hold%0d got v=%b pc=%h instr=%h addr=%h want 1/2/%h/4", i, if_valid, if_pc, if_instr, imem_addr, mem[2]);
            end
        end
        id_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== AW'(i) || if_instr !== mem[i]) begin
                n_fail++;
                $display("FAIL stall_release pc got v=%b pc=%h want 1/%h", if_valid, if_pc, i);
            end
        end
    endtask

    task automatic test_redirect;
        input logic [AW-1:0] target;
        do_reset();
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (if_valid !== 1'b0 || if_pc !== '0 || imem_addr !== target) begin
            n_fail++; $display("FAIL redir_n got v=%b pc=%h addr=%h want 0/0/%h", if_valid, if_pc, imem_addr, target);
        end
        tick();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_n1_valid got %b want 0", if_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== target + AW'(i) || if_instr !== mem[target + AW'(i)]) begin
                n_fail++;
                $display("FAIL redir_word%0d got v=%b pc=%h instr=%h want 1/%h", i, if_valid, if_pc, if_instr, target + AW'(i));
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        repeat (3) tick();
        id_ready = 1'b0;
        repeat (3) tick();
        #2;
        clr_n = 1'b0;
        #1;
        n_checks++; if (if_valid !== 1'b0 || if_pc !== '0 || if_instr !== '0 || imem_addr !== '0) begin
            n_fail++; $display("FAIL async_reset got v=%b pc=%h instr=%h addr=%h want all 0", if_valid, if_pc, if_instr, imem_addr);
        end
        id_ready = 1'b1;
        tick();
        clr_n = 1'b1;
        tick();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL async_restart_edge1 got %b want 0", if_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== AW'(i) || if_instr !== mem[i]) begin
                n_fail++;
                $display("FAIL async_restart_word%0d got v=%b pc=%h want 1/%h", i, if_valid, if_pc, i);
            end
        end
    endtask

    task automatic test_redirect_pop;
        do_reset();
        repeat (3) tick();
        id_ready = 1'b0;
        repeat (2) tick();
        n_checks++; if (if_valid !== 1'b1 || if_pc !== 10'd1) begin
            n_fail++; $display("FAIL rpop_head got v=%b pc=%h want 1/1", if_valid, if_pc);
        end
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 10'h200;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_gap%0d got v=%b pc=%h want 0", i, if_valid, if_pc); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 10'h200 + AW'(i) || if_instr !== mem[10'h200 + AW'(i)]) begin
                n_fail++; $display("FAIL rpop_word%0d got v=%b pc=%h want 1/%h", i, if_valid, if_pc, 10'h200 + AW'(i));
            end
            tick();
        end
    endtask

    // Model: once two edges have passed since reset/redirect the stream is never empty;
    // each accepted word is the next sequential PC; a redirect restarts at its target.
    task automatic test_random;
        logic [AW-1:0] exp_pc;
        int            since;
        logic          rv;
        logic [AW-1:0] rt;
        do_reset();
        exp_pc = '0;
        since = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            since++;
            n_checks++;
            if (if_valid !== (since >= 2)) begin
                n_fail++; $display("FAIL rand_valid cyc%0d got %b want %b", cyc, if_valid, since >= 2);
            end
            if (since >= 2) begin
                n_checks++;
                if (if_pc !== exp_pc || if_instr !== mem[exp_pc]) begin
                    n_fail++; $display("FAIL rand_word cyc%0d got pc=%h instr=%h want %h/%h", cyc, if_pc, if_instr, exp_pc, mem[exp_pc]);
                end
            end
            id_ready = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 15) == 0);
            rt = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(1016, 1023)) : AW'($urandom);
            redirect_valid = rv;
            redirect_pc = rt;
            if (if_valid && id_ready) exp_pc = exp_pc + 1'b1;
            if (rv) begin
                exp_pc = rt;
                since = -1;
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + i;
        test_reset();
        test_stream();
        test_stall();
        test_redirect(10'h100);
        test_redirect(10'h3FE);
        test_async_reset();
        test_redirect_pop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
